if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  IF-stage producer for the IF/ID pipeline register: owns the PC and runs a single-outstanding
//  req/gnt/rvalid handshake to instruction memory. Drives PCF/PCPlus4F/InstrF plus the IF/ID hold
//  control. Handles stall and branch/jump redirect from EX, and discards stale in-flight responses.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0) driven when no valid instruction
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   asynchronous, active-high
//  stall_i         in   1   hazard unit: hold IF and IF/ID contents
//  redirect_i      in   1   taken branch/jump; 1-cycle pulse
//  redirect_pc_i   in   32  redirect target
//  imem_req_o      out  1   fetch request, held until imem_gnt_i
//  imem_addr_o     out  32  fetch address (= PC register)
//  imem_gnt_i      in   1   request accepted this cycle
//  imem_rvalid_i   in   1   response valid (exactly one per grant, >=1 cycle after grant)
//  imem_rdata_i    in   32  response instruction word
//  PCF             out  32  PC of InstrF
//  PCPlus4F        out  32  PCF + 4
//  InstrF          out  32  fetched instruction, or NOP_INSTR when if_valid_o=0
//  if_valid_o      out  1   InstrF is a real fetched instruction
//  if_id_enable_o  out  1   IF/ID hold control; IF/ID captures when 0, holds when 1
// BEHAVIOUR
//  Reset (async): state=REQ, pc_q=RESET_PC, drop_q=0, InstrF=NOP_INSTR, if_valid_o=0,
//   imem_req_o=0 in reset cycle; PCF=RESET_PC, PCPlus4F=RESET_PC+4. imem shares reset; no response
//   from before reset is ever accepted.
//  if_id_enable_o = stall_i (combinational). Invalid slot drives NOP, so IF/ID captures a bubble.
//  States: REQ -> WAIT -> HOLD -> REQ.
//   REQ : imem_req_o=1, imem_addr_o=pc_q, if_valid_o=0. gnt -> WAIT.
//   WAIT: req=0. rvalid & !drop_q -> latch rdata into InstrF, if_valid_o=1, -> HOLD.
//         rvalid & drop_q -> discard, drop_q<=0, -> REQ.
//   HOLD: if_valid_o=1. !stall_i -> pc_q<=pc_q+4, if_valid_o<=0, -> REQ. stall_i -> stay.
//  Redirect (any state; overrides stall_i; same edge): pc_q<=redirect_pc_i, if_valid_o<=0.
//   REQ without gnt: next request uses new address, no drop.
//   REQ with gnt same cycle: old address granted -> WAIT, drop_q<=1.
//   WAIT without rvalid: drop_q<=1, stay WAIT. WAIT with rvalid: response discarded -> REQ.
//   HOLD: held instruction squashed -> REQ.
//  PCF=pc_q, PCPlus4F=pc_q+32'd4; arithmetic mod 2^32 (32'hFFFF_FFFC wraps to 0).
//  Latency: gnt in the cycle after REQ entry and rvalid the cycle after gnt -> if_valid_o
//   asserts 2 cycles after REQ entry. One fetch per >=3 cycles (no prefetch).
//  PCF/PCPlus4F/InstrF stable while if_valid_o=1 && stall_i=1.
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined: extra output misalign_o (1 bit). Redirect with
//   redirect_pc_i[1:0]!=0 sets misalign_o sticky, state HALT (req=0, if_valid_o=0, NOP driven)
//   until reset; drop_q still discards in-flight response. Undefined: no port, bits [1:0] of
//   redirect_pc_i forced to 0.
// STRUCTURE
//  Package rv_fetch_pkg: fetch_state_t enum {REQ, WAIT, HOLD, HALT}, NOP_INSTR and
//   RESET_PC defaults, XLEN=32. Single module, no sub-modules; state, pc_q, drop_q and the
//   InstrF/if_valid_o registers in one sequential process, outputs decoded combinationally.
// TESTING
//  1 Reset, gnt/rvalid 1 cycle each, rdata=32'h00500093 -> imem_addr 0,4,8;
//    InstrF=00500093 with PCF=0, PCPlus4F=4.
//  2 stall_i=1 for 5 cycles in HOLD at PCF=8 -> outputs frozen, if_id_enable_o=1,
//    no new request; release -> next request at 12.
//  3 redirect_i to 32'h100 while WAIT at addr 4 -> stale rvalid discarded (if_valid_o stays 0),
//    next request at 32'h100.
//  4 redirect_i same cycle as gnt in REQ -> drop_q=1, first response dropped,
//    re-request at target.
//  5 pc_q=32'hFFFF_FFFC -> PCPlus4F=0, next request at 0; reset asserted in WAIT ->
//    back to RESET_PC, late rvalid ignored.
//  6 FETCH_MISALIGN_CHK_EN: redirect to 32'h102 -> misalign_o=1, imem_req_o stays 0
//    until reset.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and defaults for the IF stage.
// Imported by if_fetch_unit.
package rv_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, single-outstanding req/gnt/rvalid fetch, stall/redirect, stale-response drop.
// Optional FETCH_MISALIGN_CHK_EN adds misalign_o and a HALT state on misaligned redirect targets.
module if_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic [XLEN-1:0] InstrF,
  output logic            if_valid_o,
  output logic            if_id_enable_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic            misalign_o
`endif
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_drop;
  logic            r_valid;

  logic [XLEN-1:0] w_redirect_pc;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;
  logic w_misalign;

  assign w_redirect_pc = redirect_pc_i;
  assign w_misalign    = redirect_pc_i[1:0] != 2'b00;
  assign misalign_o    = r_misalign;
`else
  logic w_unused_lsbs;

  // Without the checker, targets are forced word-aligned.
  assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_unused_lsbs = ^redirect_pc_i[1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_drop  <= 1'b0;
      r_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        REQ: begin
          if (imem_gnt_i) r_state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (r_drop || redirect_i) begin
              r_drop  <= 1'b0;
              r_state <= REQ;
            end else begin
              r_instr <= imem_rdata_i;
              r_valid <= 1'b1;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            r_pc    <= r_pc + XLEN'(4);
            r_valid <= 1'b0;
            r_state <= REQ;
          end
        end
        HALT: begin
          if (imem_rvalid_i) r_drop <= 1'b0;
        end
        default: r_state <= REQ;
      endcase

      // NOTE: redirect is applied after the state update; with non-blocking
      // assignments the later assignment wins, which gives redirect priority
      // over stall and over the normal transitions on the same edge.
      if (redirect_i) begin
        r_pc    <= w_redirect_pc;
        r_valid <= 1'b0;
        unique case (r_state)
          REQ:     if (imem_gnt_i) r_drop <= 1'b1;
          WAIT:    if (!imem_rvalid_i) r_drop <= 1'b1;
          HOLD:    r_state <= REQ;
          default: ;
        endcase
`ifdef FETCH_MISALIGN_CHK_EN
        if (w_misalign) begin
          r_misalign <= 1'b1;
          r_state    <= HALT;
        end
`endif
      end
    end
  end

  // Request is masked during reset so nothing is issued in the reset cycle.
  assign imem_req_o     = (r_state == REQ) && !reset;
  assign imem_addr_o    = r_pc;
  assign PCF            = r_pc;
  assign PCPlus4F       = r_pc + XLEN'(4);
  assign InstrF         = r_valid ? r_instr : NOP_INSTR;
  assign if_valid_o     = r_valid;
  assign if_id_enable_o = stall_i;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit; a scoreboard queue holds each granted fetch
// until its instruction appears on the IF outputs. Honours FETCH_MISALIGN_CHK_EN.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] D0     = 32'h0050_0093;
  localparam logic [31:0] D1     = 32'h0010_8113;
  localparam logic [31:0] D2     = 32'h0020_0193;
  localparam logic [31:0] STALE  = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic [31:0] InstrF;
  logic        if_valid_o;
  logic        if_id_enable_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .PCF            (PCF),
    .PCPlus4F       (PCPlus4F),
    .InstrF         (InstrF),
    .if_valid_o     (if_valid_o),
    .if_id_enable_o (if_id_enable_o)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_o     (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge, well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // One full fetch with 1-cycle gnt and 1-cycle rvalid; expected result queued at grant.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data, input string tag);
    int   t;
    exp_t e;
    t = 0;
    while (imem_req_o !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    n_checks++;
    if (imem_req_o !== 1'b1) begin
      n_errors++;
      $display("FAIL %s req_timeout: imem_req_o=%b required 1", tag, imem_req_o);
      return;
    end
    n_checks++;
    if (imem_addr_o !== exp_addr) begin
      n_errors++;
      $display("FAIL %s addr: got %h required %h", tag, imem_addr_o, exp_addr);
    end
    imem_gnt_i = 1'b1;
    sb_q.push_back('{addr: exp_addr, data: data});
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = data;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    #1;
    n_checks++;
    if (if_valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL %s valid: got %b required 1", tag, if_valid_o);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (InstrF !== e.data || PCF !== e.addr || PCPlus4F !== e.addr + 32'd4) begin
        n_errors++;
        $display("FAIL %s instr/pc: got %h/%h/%h required %h/%h/%h", tag,
                 InstrF, PCF, PCPlus4F, e.data, e.addr, e.addr + 32'd4);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_checks++;
    if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0 || InstrF !== NOP) begin
      n_errors++;
      $display("FAIL reset_outputs: got req=%b valid=%b instr=%h required 0/0/%h",
               imem_req_o, if_valid_o, InstrF, NOP);
    end
    n_checks++;
    if (PCF !== 32'h0 || PCPlus4F !== 32'h4 || if_id_enable_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_pc: got %h/%h en=%b required 0/4/0", PCF, PCPlus4F, if_id_enable_o);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_first_req: got req=%b addr=%h required 1/0", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_basic();
    do_fetch(32'h0, D0, "basic0");
    do_fetch(32'h4, D0, "basic4");
    do_fetch(32'h8, D0, "basic8");
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    #1;
    n_checks++;
    if (if_id_enable_o !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_enable: got %b required 1", if_id_enable_o);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (if_valid_o !== 1'b1 || PCF !== 32'h8 || PCPlus4F !== 32'hC || InstrF !== D0 ||
          imem_req_o !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h pc4=%h instr=%h req=%b required 1/8/c/%h/0",
                 i, if_valid_o, PCF, PCPlus4F, InstrF, imem_req_o, D0);
      end
    end
    stall_i = 1'b0;
    #1;
    n_checks++;
    if (if_id_enable_o !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_release_enable: got %b required 0", if_id_enable_o);
    end
    do_fetch(32'hC, D1, "after_stall");
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    do_fetch(32'h0, D0, "rw_first");
    tick();
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      n_errors++;
      $display("FAIL rw_req4: got req=%b addr=%h required 1/4", imem_req_o, imem_addr_o);
    end
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    n_checks++;
    if (imem_req_o !== 1'b0 || PCF !== 32'h100) begin
      n_errors++;
      $display("FAIL rw_wait: got req=%b pc=%h required 0/100", imem_req_o, PCF);
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i = STALE;
    tick();
    imem_rvalid_i = 1'b0;
    n_checks++;
    if (if_valid_o !== 1'b0 || InstrF !== NOP) begin
      n_errors++;
      $display("FAIL rw_stale_dropped: got v=%b instr=%h required 0/%h", if_valid_o, InstrF, NOP);
    end
    do_fetch(32'h100, D2, "rw_target");
  endtask

  task automatic test_redirect_gnt();
    apply_reset();
    imem_gnt_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    tick();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b0;
    n_checks++;
    if (imem_req_o !== 1'b0 || PCF !== 32'h200) begin
      n_errors++;
      $display("FAIL rg_wait: got req=%b pc=%h required 0/200", imem_req_o, PCF);
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i = STALE;
    tick();
    imem_rvalid_i = 1'b0;
    n_checks++;
    if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
      n_errors++;
      $display("FAIL rg_drop: got v=%b req=%b addr=%h required 0/1/200",
               if_valid_o, imem_req_o, imem_addr_o);
    end
    do_fetch(32'h200, D1, "rg_target");
    // Redirect in HOLD overrides a simultaneous stall.
    stall_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h300;
    tick();
    redirect_i = 1'b0;
    stall_i = 1'b0;
    n_checks++;
    if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin
      n_errors++;
      $display("FAIL rh_squash: got v=%b req=%b addr=%h required 0/1/300",
               if_valid_o, imem_req_o, imem_addr_o);
    end
    // Redirect in REQ without grant: new address, no drop.
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    do_fetch(32'h40, D2, "rq_nogrant");
  endtask

  task automatic test_wrap_and_reset();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    do_fetch(32'hFFFF_FFFC, D0, "wrap_top");
    do_fetch(32'h0, D1, "wrap_zero");
    tick();
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (PCF !== 32'h0 || imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_in_wait: got pc=%h req=%b v=%b required 0/0/0", PCF, imem_req_o, if_valid_o);
    end
    tick();
    reset = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = STALE;
    tick();
    imem_rvalid_i = 1'b0;
    n_checks++;
    if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_errors++;
      $display("FAIL late_rvalid: got v=%b req=%b addr=%h required 0/1/0",
               if_valid_o, imem_req_o, imem_addr_o);
    end
    do_fetch(32'h0, D2, "after_reset");
  endtask

  task automatic test_misalign();
    apply_reset();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h102;
    tick();
    redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || if_valid_o !== 1'b0 || InstrF !== NOP) begin
        n_errors++;
        $display("FAIL misalign_halt[%0d]: got mis=%b req=%b v=%b instr=%h required 1/0/0/%h",
                 i, misalign_o, imem_req_o, if_valid_o, InstrF, NOP);
      end
      tick();
    end
    apply_reset();
    n_checks++;
    if (misalign_o !== 1'b0 || imem_req_o !== 1'b1) begin
      n_errors++;
      $display("FAIL misalign_cleared: got mis=%b req=%b required 0/1", misalign_o, imem_req_o);
    end
`else
    do_fetch(32'h100, D1, "misalign_forced");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap_and_reset();
    test_misalign();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got %0d entries required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
